rps_round_ctrl: RTL and testbench
=================================

# rps_round_ctrl

Round controller for the rock-paper-scissors arcade datapath. It arbitrates move capture from two player inputs and drives load enables and data into the per-player 5-bit move/score registers. It runs a per-round timeout, judges the round through a combinational judge and keeps saturating 5-bit scores. It sits between the debounced button front-end and the display/score logic.

## Interface
- TIMEOUT_CYCLES, 50_000_000, maximum COLLECT duration in cycles; must be ≥ 1.
- TIMER_W, 26, timer width; must satisfy 2^TIMER_W ≥ TIMEOUT_CYCLES.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- start  in  1  level; begins a round when sampled in IDLE or DONE.
- score_clear  in  1  zeroes both scores when sampled in IDLE or DONE.
- p1_valid, p2_valid  in  1  player move strobe.
- p1_move, p2_move  in  2  move: 01 rock, 10 paper, 11 scissors, 00 none.
- p1_load, p2_load  out  1  one-cycle load enable to the player move register.
- p1_data, p2_data  out  5  zero-extended captured move, valid while the matching load is high.
- p1_locked, p2_locked  out  1  player has a captured move this round.
- result_valid  out  1  one-cycle pulse: winner and scores updated.
- winner  out  2  00 draw, 01 p1, 10 p2, 11 no contest.
- p1_score, p2_score  out  5  saturating win counts.
- busy  out  1  high in COLLECT and REVEAL.

## Operation
- Reset value of every output and internal register is 0; state is IDLE.
- States are IDLE, COLLECT, REVEAL and DONE.
- IDLE or DONE, start=1:
  - Next state is COLLECT.
  - Timer loads TIMEOUT_CYCLES-1.
  - Locks clear and winner clears to 00.
- COLLECT, accept rule: player n is accepted when pn_valid=1, pn_move≠00 and pn_locked=0.
  - Both players may be accepted in the same cycle.
  - Invalid moves (00) and strobes after lock are ignored.
- COLLECT, capture on accept, at the next edge:
  - pn_locked=1.
  - pn_load=1 for one cycle.
  - pn_data = {3'b0, move}.
  - The move is held internally for judging.
- COLLECT, timer: decrements by 1 each cycle.
- COLLECT, exit: go to REVEAL when both locks are 1 after this edge (counting same-cycle accepts), or when the timer is 0.
  - An accept in the timer==0 cycle still counts.
- REVEAL (exactly 1 cycle): winner is computed from the lock pattern and moves.
  - Both locked: rock beats scissors, scissors beats paper, paper beats rock; equal moves give 00.
  - Only p1 locked: 01 (forfeit).
  - Only p2 locked: 10 (forfeit).
  - Neither locked: 11.
- REVEAL, scoring: the winner's score increments, saturating at 31. 00 and 11 change no score.
- REVEAL exit: next state is DONE with result_valid=1 for the first DONE cycle.
- DONE: winner, locks and scores are held until start.
- start is ignored in COLLECT and REVEAL.
- score_clear in COLLECT/REVEAL is ignored.
- score_clear and start in the same IDLE/DONE cycle both take effect: scores go to 0 and a round begins.
- Reset asserted mid-round aborts immediately.
  - All outputs go to 0 asynchronously.
  - No load or result pulse is emitted.

## Timing
- start sampled at edge k: COLLECT from k+1; busy=1 from k+1.
- Both players accepted in cycle c: locks and load pulses in c+1 with state=REVEAL; DONE with result_valid in c+2.
- Single accept in cycle c: load pulse in c+1 only.
- Timeout: COLLECT lasts at most TIMEOUT_CYCLES cycles, then REVEAL 1 cycle, then DONE.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Shared package rps_pkg holds:
  - move constants (MOVE_NONE/ROCK/PAPER/SCISSORS);
  - winner constants (WIN_DRAW/P1/P2/NONE);
  - the state enum;
  - SCORE_W=5 and SCORE_MAX=31.
- One sub-module, rps_judge: purely combinational. Inputs are two moves plus two lock bits; output is a 2-bit winner. It is reused by the attract-mode demo.
- The timer, FSM and score counters are inline in rps_round_ctrl.

## Test plan
- Reset, start, p1 rock and p2 scissors in the same cycle c:
  - loads in c+1 with p1_data=00001, p2_data=00011;
  - result_valid in c+2 with winner=01, p1_score=1.
- TIMEOUT_CYCLES=8, start, p2 paper only:
  - REVEAL after 8 COLLECT cycles;
  - winner=10, p2_score=1.
- TIMEOUT_CYCLES=4, no moves: winner=11, both scores unchanged.
- Duplicate strobes, move=00 and strobes in DONE:
  - exactly one p1_load per round;
  - 00 produces no lock.
- 32 p1 wins: p1_score saturates at 31. Then score_clear with start in DONE gives both scores 0 and busy=1 next cycle.
- Reset asserted mid-COLLECT with p1 locked:
  - all outputs 0 immediately and state IDLE;
  - after release, start runs a clean round.

Source files
------------

// File: rtl/rps_round_ctrl_pkg.sv
// Shared constants, state encoding and score helper for the rock-paper-scissors
// round controller and its attract-mode companions.
package rps_pkg;

  localparam int SCORE_W = 5;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 5'd31;

  localparam logic [1:0] MOVE_NONE     = 2'b00;
  localparam logic [1:0] MOVE_ROCK     = 2'b01;
  localparam logic [1:0] MOVE_PAPER    = 2'b10;
  localparam logic [1:0] MOVE_SCISSORS = 2'b11;

  localparam logic [1:0] WIN_DRAW = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_REVEAL,
    ST_DONE
  } state_e;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/rps_round_ctrl_if.sv
// Player/score bus between the button front-end, the round controller and the
// display logic. master drives the player side, slave is the controller.
interface rps_round_ctrl_if;
  import rps_pkg::*;

  logic               start;
  logic               score_clear;
  logic               p1_valid;
  logic               p2_valid;
  logic [1:0]         p1_move;
  logic [1:0]         p2_move;
  logic               p1_load;
  logic               p2_load;
  logic [SCORE_W-1:0] p1_data;
  logic [SCORE_W-1:0] p2_data;
  logic               p1_locked;
  logic               p2_locked;
  logic               result_valid;
  logic [1:0]         winner;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic               busy;

  modport master (
    output start, score_clear, p1_valid, p2_valid, p1_move, p2_move,
    input  p1_load, p2_load, p1_data, p2_data, p1_locked, p2_locked,
           result_valid, winner, p1_score, p2_score, busy
  );

  modport slave (
    input  start, score_clear, p1_valid, p2_valid, p1_move, p2_move,
    output p1_load, p2_load, p1_data, p2_data, p1_locked, p2_locked,
           result_valid, winner, p1_score, p2_score, busy
  );

endinterface

// File: rtl/rps_round_ctrl_judge.sv
// Combinational round judge: decides the winner from both moves and lock bits.
module rps_judge
  import rps_pkg::*;
(
  input  logic [1:0] p1_move,
  input  logic [1:0] p2_move,
  input  logic       p1_locked,
  input  logic       p2_locked,
  output logic [1:0] winner
);

  logic p1_beats;

  always_comb begin
    p1_beats = ((p1_move == MOVE_ROCK)     && (p2_move == MOVE_SCISSORS)) ||
               ((p1_move == MOVE_SCISSORS) && (p2_move == MOVE_PAPER))    ||
               ((p1_move == MOVE_PAPER)    && (p2_move == MOVE_ROCK));
    winner = WIN_NONE;
    case ({p1_locked, p2_locked})
      2'b11: begin
        if (p1_move == p2_move) winner = WIN_DRAW;
        else if (p1_beats)      winner = WIN_P1;
        else                    winner = WIN_P2;
      end
      2'b10:   winner = WIN_P1;
      2'b01:   winner = WIN_P2;
      default: winner = WIN_NONE;
    endcase
  end

endmodule

// File: rtl/rps_round_ctrl.sv
// Round controller: captures one move per player, times out the collect phase,
// judges the round and keeps saturating scores. Every output is a flop.
module rps_round_ctrl
  import rps_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TIMER_W        = 26
) (
  input  logic          clk,
  input  logic          reset,
  rps_round_ctrl_if.slave bus
);

  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               p1_locked_q, p1_locked_d, p2_locked_q, p2_locked_d;
  logic [1:0]         p1_move_q, p1_move_d, p2_move_q, p2_move_d;
  logic               p1_load_q, p1_load_d, p2_load_q, p2_load_d;
  logic [SCORE_W-1:0] p1_data_q, p1_data_d, p2_data_q, p2_data_d;
  logic               result_valid_q, result_valid_d;
  logic [1:0]         winner_q, winner_d;
  logic [SCORE_W-1:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic               busy_q, busy_d;
  logic [1:0]         judge_win;
  logic               p1_accept, p2_accept;

  rps_judge u_judge (
    .p1_move   (p1_move_q),
    .p2_move   (p2_move_q),
    .p1_locked (p1_locked_q),
    .p2_locked (p2_locked_q),
    .winner    (judge_win)
  );

  assign p1_accept = bus.p1_valid && (bus.p1_move != MOVE_NONE) && !p1_locked_q;
  assign p2_accept = bus.p2_valid && (bus.p2_move != MOVE_NONE) && !p2_locked_q;

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    p1_locked_d    = p1_locked_q;
    p2_locked_d    = p2_locked_q;
    p1_move_d      = p1_move_q;
    p2_move_d      = p2_move_q;
    p1_data_d      = p1_data_q;
    p2_data_d      = p2_data_q;
    winner_d       = winner_q;
    p1_score_d     = p1_score_q;
    p2_score_d     = p2_score_q;
    p1_load_d      = 1'b0;
    p2_load_d      = 1'b0;
    result_valid_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.score_clear) begin
          p1_score_d = '0;
          p2_score_d = '0;
        end
        if (bus.start) begin
          state_d     = ST_COLLECT;
          timer_d     = TIMER_LOAD;
          p1_locked_d = 1'b0;
          p2_locked_d = 1'b0;
          p1_move_d   = MOVE_NONE;
          p2_move_d   = MOVE_NONE;
          winner_d    = WIN_DRAW;
        end
      end
      ST_COLLECT: begin
        if (p1_accept) begin
          p1_locked_d = 1'b1;
          p1_load_d   = 1'b1;
          p1_move_d   = bus.p1_move;
          p1_data_d   = {{(SCORE_W-2){1'b0}}, bus.p1_move};
        end
        if (p2_accept) begin
          p2_locked_d = 1'b1;
          p2_load_d   = 1'b1;
          p2_move_d   = bus.p2_move;
          p2_data_d   = {{(SCORE_W-2){1'b0}}, bus.p2_move};
        end
        // A move accepted in the timer==0 cycle still reaches the judge.
        if (timer_q != '0) timer_d = timer_q - 1'b1;
        if ((p1_locked_d && p2_locked_d) || (timer_q == '0)) state_d = ST_REVEAL;
      end
      ST_REVEAL: begin
        winner_d       = judge_win;
        if (judge_win == WIN_P1) p1_score_d = sat_inc(p1_score_q);
        if (judge_win == WIN_P2) p2_score_d = sat_inc(p2_score_q);
        result_valid_d = 1'b1;
        state_d        = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_COLLECT) || (state_d == ST_REVEAL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      p1_locked_q    <= 1'b0;
      p2_locked_q    <= 1'b0;
      p1_move_q      <= MOVE_NONE;
      p2_move_q      <= MOVE_NONE;
      p1_load_q      <= 1'b0;
      p2_load_q      <= 1'b0;
      p1_data_q      <= '0;
      p2_data_q      <= '0;
      result_valid_q <= 1'b0;
      winner_q       <= WIN_DRAW;
      p1_score_q     <= '0;
      p2_score_q     <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      p1_locked_q    <= p1_locked_d;
      p2_locked_q    <= p2_locked_d;
      p1_move_q      <= p1_move_d;
      p2_move_q      <= p2_move_d;
      p1_load_q      <= p1_load_d;
      p2_load_q      <= p2_load_d;
      p1_data_q      <= p1_data_d;
      p2_data_q      <= p2_data_d;
      result_valid_q <= result_valid_d;
      winner_q       <= winner_d;
      p1_score_q     <= p1_score_d;
      p2_score_q     <= p2_score_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.p1_load      = p1_load_q;
  assign bus.p2_load      = p2_load_q;
  assign bus.p1_data      = p1_data_q;
  assign bus.p2_data      = p2_data_q;
  assign bus.p1_locked    = p1_locked_q;
  assign bus.p2_locked    = p2_locked_q;
  assign bus.result_valid = result_valid_q;
  assign bus.winner       = winner_q;
  assign bus.p1_score     = p1_score_q;
  assign bus.p2_score     = p2_score_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Bench for rps_round_ctrl: table of head-to-head rounds plus hand-written
// timeout, duplicate-strobe, saturation and mid-round reset sequences.
module tb_rps_round_ctrl;
  import rps_pkg::*;

  logic clk;
  logic rst;

  rps_round_ctrl_if ifa ();
  rps_round_ctrl_if ifb ();

  rps_round_ctrl #(.TIMEOUT_CYCLES(8), .TIMER_W(4)) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (ifa.slave)
  );

  rps_round_ctrl #(.TIMEOUT_CYCLES(4), .TIMER_W(3)) dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] m1;
    logic [1:0] m2;
    logic [1:0] win;
  } vec_t;

  typedef struct {
    logic [1:0] win;
    int         p1s;
    int         p2s;
  } exp_t;

  vec_t vecs[9];
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_p1 = 0;
  int   exp_p2 = 0;
  int   p1_load_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs_a();
    return 32'({ifa.p1_load, ifa.p2_load, ifa.p1_data, ifa.p2_data, ifa.p1_locked,
                ifa.p2_locked, ifa.result_valid, ifa.winner, ifa.p1_score,
                ifa.p2_score, ifa.busy});
  endfunction

  function automatic logic [31:0] outs_b();
    return 32'({ifb.p1_load, ifb.p2_load, ifb.p1_data, ifb.p2_data, ifb.p1_locked,
                ifb.p2_locked, ifb.result_valid, ifb.winner, ifb.p1_score,
                ifb.p2_score, ifb.busy});
  endfunction

  task automatic sb_push(input logic [1:0] win);
    exp_t e;
    if (win == WIN_P1 && exp_p1 < 31) exp_p1++;
    if (win == WIN_P2 && exp_p2 < 31) exp_p2++;
    e.win = win;
    e.p1s = exp_p1;
    e.p2s = exp_p2;
    sb_q.push_back(e);
  endtask

  // Advance one clock; observe DUT A just after the edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (ifa.p1_load) p1_load_cnt++;
    if (ifa.result_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_result", 32'(ifa.result_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_winner", 32'(ifa.winner), 32'(e.win));
        check("sb_p1_score", 32'(ifa.p1_score), e.p1s);
        check("sb_p2_score", 32'(ifa.p2_score), e.p2s);
      end
    end
  endtask

  task automatic start_a();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    check("start_busy_a", 32'(ifa.busy), 32'd1);
  endtask

  task automatic wait_rv(input bit use_b, output int n);
    n = 0;
    while (!(use_b ? ifb.result_valid : ifa.result_valid) && n < 40) begin
      tick();
      n++;
    end
    check(use_b ? "rv_b_seen" : "rv_a_seen",
          32'(use_b ? ifb.result_valid : ifa.result_valid), 32'd1);
  endtask

  initial begin
    int n;
    int cnt0;

    vecs[0] = '{MOVE_ROCK,     MOVE_SCISSORS, WIN_P1};
    vecs[1] = '{MOVE_ROCK,     MOVE_ROCK,     WIN_DRAW};
    vecs[2] = '{MOVE_ROCK,     MOVE_PAPER,    WIN_P2};
    vecs[3] = '{MOVE_PAPER,    MOVE_ROCK,     WIN_P1};
    vecs[4] = '{MOVE_PAPER,    MOVE_PAPER,    WIN_DRAW};
    vecs[5] = '{MOVE_PAPER,    MOVE_SCISSORS, WIN_P2};
    vecs[6] = '{MOVE_SCISSORS, MOVE_ROCK,     WIN_P2};
    vecs[7] = '{MOVE_SCISSORS, MOVE_PAPER,    WIN_P1};
    vecs[8] = '{MOVE_SCISSORS, MOVE_SCISSORS, WIN_DRAW};

    rst = 1'b1;
    {ifa.start, ifa.score_clear, ifa.p1_valid, ifa.p2_valid} = '0;
    {ifb.start, ifb.score_clear, ifb.p1_valid, ifb.p2_valid} = '0;
    ifa.p1_move = MOVE_NONE; ifa.p2_move = MOVE_NONE;
    ifb.p1_move = MOVE_NONE; ifb.p2_move = MOVE_NONE;
    tick();
    tick();
    check("reset_outs_a", outs_a(), 32'd0);
    check("reset_outs_b", outs_b(), 32'd0);
    rst = 1'b0;
    tick();

    // Head-to-head rounds, both players accepted in the same cycle.
    for (int i = 0; i < 9; i++) begin
      start_a();
      ifa.p1_valid = 1'b1; ifa.p1_move = vecs[i].m1;
      ifa.p2_valid = 1'b1; ifa.p2_move = vecs[i].m2;
      sb_push(vecs[i].win);
      tick();
      ifa.p1_valid = 1'b0; ifa.p2_valid = 1'b0;
      check("tbl_loads", {30'd0, ifa.p1_load, ifa.p2_load}, 32'd3);
      check("tbl_p1_data", 32'(ifa.p1_data), {27'd0, 3'b000, vecs[i].m1});
      check("tbl_p2_data", 32'(ifa.p2_data), {27'd0, 3'b000, vecs[i].m2});
      check("tbl_locks", {30'd0, ifa.p1_locked, ifa.p2_locked}, 32'd3);
      tick();
      check("tbl_rv_c2", 32'(ifa.result_valid), 32'd1);
      tick();
      check("tbl_rv_pulse", 32'(ifa.result_valid), 32'd0);
      check("tbl_winner_held", 32'(ifa.winner), 32'(vecs[i].win));
    end

    // Timeout with only p2 playing paper.
    start_a();
    ifa.p2_valid = 1'b1; ifa.p2_move = MOVE_PAPER;
    sb_push(WIN_P2);
    tick();
    ifa.p2_valid = 1'b0;
    check("to_loads", {30'd0, ifa.p1_load, ifa.p2_load}, 32'd1);
    check("to_p2_data", 32'(ifa.p2_data), 32'd2);
    wait_rv(1'b0, n);
    check("to_cycles", n + 1, 32'd9);
    check("to_winner", 32'(ifa.winner), 32'(WIN_P2));

    // Null moves, duplicate strobes and strobes in DONE.
    start_a();
    cnt0 = p1_load_cnt;
    ifa.p1_valid = 1'b1; ifa.p1_move = MOVE_NONE;
    tick();
    check("none_no_lock", 32'(ifa.p1_locked), 32'd0);
    ifa.p1_move = MOVE_ROCK;
    tick();
    tick();
    tick();
    ifa.p1_valid = 1'b0;
    check("dup_locked", 32'(ifa.p1_locked), 32'd1);
    check("dup_busy", 32'(ifa.busy), 32'd1);
    ifa.p2_valid = 1'b1; ifa.p2_move = MOVE_PAPER;
    sb_push(WIN_P2);
    tick();
    ifa.p2_valid = 1'b0;
    tick();
    check("dup_rv", 32'(ifa.result_valid), 32'd1);
    ifa.p1_valid = 1'b1; ifa.p1_move = MOVE_SCISSORS;
    tick();
    tick();
    ifa.p1_valid = 1'b0;
    check("done_strobe_no_load", 32'(ifa.p1_load), 32'd0);
    check("one_p1_load", p1_load_cnt - cnt0, 32'd1);
    check("done_busy", 32'(ifa.busy), 32'd0);

    // 32 p1 wins drive the score into saturation.
    for (int r = 0; r < 32; r++) begin
      start_a();
      ifa.p1_valid = 1'b1; ifa.p1_move = MOVE_ROCK;
      ifa.p2_valid = 1'b1; ifa.p2_move = MOVE_SCISSORS;
      sb_push(WIN_P1);
      tick();
      ifa.p1_valid = 1'b0; ifa.p2_valid = 1'b0;
      tick();
    end
    check("sat_p1", 32'(ifa.p1_score), 32'd31);
    ifa.score_clear = 1'b1; ifa.start = 1'b1;
    tick();
    ifa.score_clear = 1'b0; ifa.start = 1'b0;
    exp_p1 = 0; exp_p2 = 0;
    check("clr_scores", {22'd0, ifa.p1_score, ifa.p2_score}, 32'd0);
    check("clr_busy", 32'(ifa.busy), 32'd1);
    sb_push(WIN_NONE);
    wait_rv(1'b0, n);

    // Four-cycle timeout instance: forfeit win, then an empty round.
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    ifb.p1_valid = 1'b1; ifb.p1_move = MOVE_ROCK;
    tick();
    ifb.p1_valid = 1'b0;
    wait_rv(1'b1, n);
    check("b_forfeit_winner", 32'(ifb.winner), 32'(WIN_P1));
    check("b_forfeit_score", 32'(ifb.p1_score), 32'd1);
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    wait_rv(1'b1, n);
    check("b_empty_cycles", n, 32'd5);
    check("b_empty_winner", 32'(ifb.winner), 32'(WIN_NONE));
    check("b_empty_scores", {22'd0, ifb.p1_score, ifb.p2_score}, 32'h20);

    // Reset mid-collect with p1 already locked.
    start_a();
    ifa.p1_valid = 1'b1; ifa.p1_move = MOVE_ROCK;
    tick();
    ifa.p1_valid = 1'b0;
    check("rst_pre_lock", 32'(ifa.p1_locked), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_outs", outs_a(), 32'd0);
    exp_p1 = 0; exp_p2 = 0;
    tick();
    rst = 1'b0;
    tick();
    check("rst_idle_outs", outs_a(), 32'd0);
    start_a();
    ifa.p1_valid = 1'b1; ifa.p1_move = MOVE_ROCK;
    ifa.p2_valid = 1'b1; ifa.p2_move = MOVE_PAPER;
    sb_push(WIN_P2);
    tick();
    ifa.p1_valid = 1'b0; ifa.p2_valid = 1'b0;
    tick();
    check("post_rst_rv", 32'(ifa.result_valid), 32'd1);
    check("post_rst_scores", {22'd0, ifa.p1_score, ifa.p2_score}, 32'd1);
    tick();

    check("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
